truth_table_lut: RTL and testbench

- Parametrised, run-time-programmable truth-table evaluator: NUM_OUT independent functions of N_IN shared inputs, each stored as a 2^N_IN-bit table.
- Registered evaluation path with valid strobe.
- Serial configuration port loads a shadow table, committed atomically, so evaluation never sees a partial table.
- Generalises fixed-function truth-table gates into a reusable combinational-logic engine for the Basic Gates / Combinational Logic designs.

---
 rtl/truth_table_pkg.sv | 18 +
 rtl/truth_table_cfg_loader.sv | 75 +++++++
 rtl/truth_table_lut.sv | 96 +++++++++
 tb/tb_truth_table_lut.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and sizing helpers for the truth_table_lut slice.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } cfg_state_e;

  function automatic int unsigned TOTAL(input int unsigned n_in, input int unsigned num_out);
    return num_out << n_in;
  endfunction

  function automatic int unsigned CNT_W(input int unsigned total);
    return $clog2(total) + 1;
  endfunction

endpackage

// File: rtl/truth_table_cfg_loader.sv
// Serial table loader: shifts cfg bits into a shadow table and raises commit
// for one cycle once the last bit has been written.
module truth_table_cfg_loader
  import truth_table_pkg::*;
#(
  parameter int unsigned N_IN    = 3,
  parameter int unsigned NUM_OUT = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cfg_start,
  input  logic                              cfg_valid,
  input  logic                              cfg_bit,
  output logic [TOTAL(N_IN, NUM_OUT)-1:0]   shadow,
  output logic                              commit,
  output logic                              busy
);

  localparam int unsigned TOT = TOTAL(N_IN, NUM_OUT);
  localparam int unsigned CW  = CNT_W(TOT);
  localparam int unsigned AW  = CW - 1;

  cfg_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, widx;
  logic          wr;
  logic          restart;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    widx     = cnt;
    wr       = 1'b0;
    restart  = 1'b0;
    busy     = (state != IDLE);
    commit   = (state == COMMIT);
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nx = LOAD;
          cnt_nx   = '0;
          restart  = 1'b1;
        end
      end
      LOAD: begin
        // A restart with a simultaneous bit writes that bit as bit 0.
        if (cfg_start) begin
          widx    = '0;
          cnt_nx  = '0;
          restart = 1'b1;
        end
        if (cfg_valid) begin
          wr     = 1'b1;
          cnt_nx = widx + CW'(1);
          if (widx == CW'(TOT - 1)) state_nx = COMMIT;
        end
      end
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (restart) shadow <= '0;
      if (wr) shadow[widx[AW-1:0]] <= cfg_bit;
    end
  end

endmodule

// File: rtl/truth_table_lut.sv
// Run-time programmable truth-table evaluator with registered outputs.
// Optional per-output hit counters are enabled by defining LUT_HITCOUNT_EN.
module truth_table_lut
  import truth_table_pkg::*;
#(
  parameter int unsigned                    N_IN    = 3,
  parameter int unsigned                    NUM_OUT = 1,
  parameter logic [TOTAL(N_IN, NUM_OUT)-1:0] INIT   = 'hAC
`ifdef LUT_HITCOUNT_EN
  ,
  parameter int unsigned                    HIT_W   = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [N_IN-1:0]    x,
  output logic               out_valid,
  output logic [NUM_OUT-1:0] f,
  input  logic               cfg_start,
  input  logic               cfg_valid,
  input  logic               cfg_bit,
  output logic               cfg_busy,
  output logic               cfg_done
`ifdef LUT_HITCOUNT_EN
  ,
  output logic [NUM_OUT*HIT_W-1:0] hit_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << N_IN;
  localparam int unsigned TOT   = TOTAL(N_IN, NUM_OUT);

  logic [TOT-1:0]                   active;
  logic [TOT-1:0]                   shadow;
  logic                             commit;
  logic [NUM_OUT-1:0][DEPTH-1:0]    tbl;
  logic [NUM_OUT-1:0]               f_nx;

  truth_table_cfg_loader #(
    .N_IN   (N_IN),
    .NUM_OUT(NUM_OUT)
  ) u_loader (
    .clk      (clk),
    .reset    (reset),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_bit  (cfg_bit),
    .shadow   (shadow),
    .commit   (commit),
    .busy     (cfg_busy)
  );

  assign cfg_done = commit;
  assign tbl      = active;

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_lookup
    assign f_nx[o] = tbl[o][x];
  end

  // The active table updates at the end of the commit cycle, so a lookup
  // issued during commit still sees the previous table.
  always_ff @(posedge clk) begin
    if (reset) begin
      active    <= INIT;
      out_valid <= 1'b0;
      f         <= '0;
    end else begin
      if (commit) active <= shadow;
      out_valid <= in_valid;
      if (in_valid) f <= f_nx;
    end
  end

`ifdef LUT_HITCOUNT_EN
  for (genvar o = 0; o < NUM_OUT; o++) begin : g_hits
    logic [HIT_W-1:0] hc;
    logic             hit;

    assign hit = in_valid & f_nx[o];

    always_ff @(posedge clk) begin
      if (reset) begin
        hc <= '0;
      end else if (commit) begin
        hc <= hit ? HIT_W'(1) : '0;
      end else if (hit && (hc != '1)) begin
        hc <= hc + HIT_W'(1);
      end
    end

    assign hit_cnt[o*HIT_W +: HIT_W] = hc;
  end
`endif

endmodule

// File: tb/tb_truth_table_lut.sv
// Directed bench for truth_table_lut: default 3-input table and a 2x2-input variant.
module tb_truth_table_lut;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       a_in_valid, a_out_valid;
  logic [2:0] a_x;
  logic [0:0] a_f;
  logic       a_cfg_start, a_cfg_valid, a_cfg_bit, a_busy, a_done;

  logic       b_in_valid, b_out_valid;
  logic [1:0] b_x;
  logic [1:0] b_f;
  logic       b_cfg_start, b_cfg_valid, b_cfg_bit, b_busy, b_done;

`ifdef LUT_HITCOUNT_EN
  logic [1:0]  a_hit;
  logic [31:0] b_hit;
`endif

  int checks = 0;
  int failures = 0;
  int busy_seen;
  int done_seen;

  truth_table_lut #(
    .N_IN   (3),
    .NUM_OUT(1),
    .INIT   (8'hAC)
`ifdef LUT_HITCOUNT_EN
    ,
    .HIT_W  (2)
`endif
  ) u_a (
    .clk      (clk),
    .reset    (reset),
    .in_valid (a_in_valid),
    .x        (a_x),
    .out_valid(a_out_valid),
    .f        (a_f),
    .cfg_start(a_cfg_start),
    .cfg_valid(a_cfg_valid),
    .cfg_bit  (a_cfg_bit),
    .cfg_busy (a_busy),
    .cfg_done (a_done)
`ifdef LUT_HITCOUNT_EN
    ,
    .hit_cnt  (a_hit)
`endif
  );

  truth_table_lut #(
    .N_IN   (2),
    .NUM_OUT(2),
    .INIT   (8'h86)
  ) u_b (
    .clk      (clk),
    .reset    (reset),
    .in_valid (b_in_valid),
    .x        (b_x),
    .out_valid(b_out_valid),
    .f        (b_f),
    .cfg_start(b_cfg_start),
    .cfg_valid(b_cfg_valid),
    .cfg_bit  (b_cfg_bit),
    .cfg_busy (b_busy),
    .cfg_done (b_done)
`ifdef LUT_HITCOUNT_EN
    ,
    .hit_cnt  (b_hit)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [7:0] val);
    busy_seen = 0;
    done_seen = 0;
    a_cfg_start = 1'b1;
    tick();
    a_cfg_start = 1'b0;
    if (a_busy) busy_seen++;
    if (a_done) done_seen++;
    for (int k = 0; k < 8; k++) begin
      a_cfg_valid = 1'b1;
      a_cfg_bit   = val[k];
      tick();
      if (a_busy) busy_seen++;
      if (a_done) done_seen++;
    end
    a_cfg_valid = 1'b0;
    a_cfg_bit   = 1'b0;
  endtask

  task automatic test_reset();
    a_in_valid = 0; a_x = '0; a_cfg_start = 0; a_cfg_valid = 0; a_cfg_bit = 0;
    b_in_valid = 0; b_x = '0; b_cfg_start = 0; b_cfg_valid = 0; b_cfg_bit = 0;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_f !== 1'b0) begin
      failures++;
      $display("FAIL reset_a_out out_valid=%b f=%b expected 0 0", a_out_valid, a_f);
    end
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_a_cfg busy=%b done=%b expected 0 0", a_busy, a_done);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_f !== 2'b00 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_b out_valid=%b f=%b busy=%b expected 0 00 0", b_out_valid, b_f, b_busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_default_sweep();
    logic [7:0] exp;
    exp = 8'hAC;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_x = i[2:0];
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_f[0] !== exp[i[2:0]]) begin
        failures++;
        $display("FAIL default_sweep x=%0d out_valid=%b f=%b expected 1 %b", i, a_out_valid, a_f, exp[i[2:0]]);
      end
    end
    a_in_valid = 1'b0;
    a_x = 3'd0;
    tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_f !== 1'b1) begin
      failures++;
      $display("FAIL default_hold out_valid=%b f=%b expected 0 1", a_out_valid, a_f);
    end
  endtask

  task automatic test_midload_restart();
    a_cfg_start = 1'b1;
    tick();
    a_cfg_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_cfg_valid = 1'b1;
      a_cfg_bit   = 1'b0;
      tick();
    end
    a_cfg_valid = 1'b0;
    a_in_valid  = 1'b1;
    a_x         = 3'd2;
    tick();
    a_in_valid  = 1'b0;
    checks++;
    if (a_f !== 1'b1 || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL midload_eval f=%b busy=%b expected 1 1", a_f, a_busy);
    end
    a_cfg_start = 1'b1;
    a_cfg_valid = 1'b1;
    a_cfg_bit   = 1'b1;
    tick();
    a_cfg_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (a_done !== 1'b0 || a_busy !== 1'b1) begin
        failures++;
        $display("FAIL restart_loading step=%0d busy=%b done=%b expected 1 0", k, a_busy, a_done);
      end
      tick();
    end
    a_cfg_valid = 1'b0;
    a_cfg_bit   = 1'b0;
    checks++;
    if (a_done !== 1'b1) begin
      failures++;
      $display("FAIL restart_commit done=%b expected 1", a_done);
    end
    a_in_valid = 1'b1;
    a_x = 3'd0;
    tick();
    checks++;
    if (a_f !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL ff_commit_cycle f=%b done=%b expected 0 0", a_f, a_done);
    end
    for (int i = 0; i < 8; i++) begin
      a_x = i[2:0];
      tick();
      checks++;
      if (a_f !== 1'b1) begin
        failures++;
        $display("FAIL ff_sweep x=%0d f=%b expected 1", i, a_f);
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_xor3();
    logic [7:0] exp;
    exp = 8'h96;
    a_cfg_valid = 1'b1;
    a_cfg_bit   = 1'b0;
    tick();
    tick();
    a_cfg_valid = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL idle_cfg_valid busy=%b done=%b expected 0 0", a_busy, a_done);
    end
    load_a(8'h96);
    checks++;
    if (a_done !== 1'b1 || busy_seen != 9 || done_seen != 1) begin
      failures++;
      $display("FAIL xor3_load done=%b busy_cycles=%0d done_pulses=%0d expected 1 9 1", a_done, busy_seen, done_seen);
    end
    tick();
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL xor3_idle busy=%b done=%b expected 0 0", a_busy, a_done);
    end
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_x = i[2:0];
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_f[0] !== exp[i[2:0]]) begin
        failures++;
        $display("FAIL xor3_sweep x=%0d f=%b expected %b", i, a_f, exp[i[2:0]]);
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_commit_race();
    load_a(8'h01);
    a_in_valid  = 1'b1;
    a_x         = 3'd0;
    a_cfg_start = 1'b1;
    tick();
    a_cfg_start = 1'b0;
    checks++;
    if (a_f !== 1'b0 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL race_commit_cycle f=%b busy=%b expected 0 0", a_f, a_busy);
    end
    tick();
    checks++;
    if (a_f !== 1'b1) begin
      failures++;
      $display("FAIL race_next_cycle f=%b expected 1", a_f);
    end
    a_x = 3'd1;
    tick();
    checks++;
    if (a_f !== 1'b0) begin
      failures++;
      $display("FAIL race_row1 f=%b expected 0", a_f);
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_multi_out();
    logic [1:0] exp [4];
    exp[0] = 2'b00; exp[1] = 2'b01; exp[2] = 2'b01; exp[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_x = i[1:0];
      tick();
      checks++;
      if (b_out_valid !== 1'b1 || b_f !== exp[i]) begin
        failures++;
        $display("FAIL multi_init x=%0d f=%b expected %b", i, b_f, exp[i]);
      end
    end
    b_in_valid = 1'b0;
    b_cfg_start = 1'b1;
    tick();
    b_cfg_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      b_cfg_valid = 1'b1;
      b_cfg_bit   = 1'b1;
      tick();
    end
    b_cfg_valid = 1'b0;
    checks++;
    if (b_done !== 1'b1) begin
      failures++;
      $display("FAIL multi_commit done=%b expected 1", b_done);
    end
    tick();
    b_in_valid = 1'b1;
    b_x = 2'd0;
    tick();
    b_in_valid = 1'b0;
    checks++;
    if (b_f !== 2'b11) begin
      failures++;
      $display("FAIL multi_loaded f=%b expected 11", b_f);
    end
    b_cfg_start = 1'b1;
    tick();
    b_cfg_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b_cfg_valid = 1'b1;
      b_cfg_bit   = 1'b0;
      tick();
    end
    b_cfg_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (b_busy !== 1'b0 || b_done !== 1'b0) begin
      failures++;
      $display("FAIL multi_reset_cfg busy=%b done=%b expected 0 0", b_busy, b_done);
    end
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_x = i[1:0];
      tick();
      checks++;
      if (b_f !== exp[i]) begin
        failures++;
        $display("FAIL multi_restored x=%0d f=%b expected %b", i, b_f, exp[i]);
      end
    end
    b_in_valid = 1'b0;
    tick();
    checks++;
    if (b_busy !== 1'b0) begin
      failures++;
      $display("FAIL multi_stays_idle busy=%b expected 0", b_busy);
    end
  endtask

`ifdef LUT_HITCOUNT_EN
  task automatic test_hitcount();
    logic [1:0] exp [6];
    exp[0] = 2'd1; exp[1] = 2'd2; exp[2] = 2'd3; exp[3] = 2'd3; exp[4] = 2'd3; exp[5] = 2'd3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (a_hit !== 2'd0) begin
      failures++;
      $display("FAIL hit_reset hit_cnt=%0d expected 0", a_hit);
    end
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_x = 3'd2;
      tick();
      checks++;
      if (a_hit !== exp[i]) begin
        failures++;
        $display("FAIL hit_count n=%0d hit_cnt=%0d expected %0d", i + 1, a_hit, exp[i]);
      end
    end
    a_x = 3'd0;
    tick();
    a_in_valid = 1'b0;
    checks++;
    if (a_hit !== 2'd3) begin
      failures++;
      $display("FAIL hit_miss hit_cnt=%0d expected 3", a_hit);
    end
    load_a(8'hAC);
    tick();
    checks++;
    if (a_hit !== 2'd0) begin
      failures++;
      $display("FAIL hit_commit_clear hit_cnt=%0d expected 0", a_hit);
    end
    load_a(8'hAC);
    a_in_valid = 1'b1;
    a_x = 3'd2;
    tick();
    a_in_valid = 1'b0;
    checks++;
    if (a_hit !== 2'd1) begin
      failures++;
      $display("FAIL hit_commit_same_cycle hit_cnt=%0d expected 1", a_hit);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_sweep();
    test_midload_restart();
    test_xor3();
    test_commit_race();
    test_multi_out();
`ifdef LUT_HITCOUNT_EN
    test_hitcount();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
